fft_r22sdf_ctrl: RTL

- Sequencer for a radix-2² single-delay-feedback FFT pipeline of STAGES = N_LOG2/2 stage pairs (BF-I, BF-II, twiddle multiplier).
- Generates every butterfly sel/tsel control, the per-stage twiddle index, the input handshake, the output framing and the datapath flush/recovery controls.
- Butterfly shift registers advance every clock with no enable, so frames enter as N back-to-back samples; this block enforces that rule and recovers when it is broken.

---
 rtl/fft_r22sdf_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_r22sdf_ctrl.sv
// Control sequencer for a radix-2^2 SDF FFT pipeline: butterfly sel/tsel, twiddle
// indices, input handshake, output framing and gap recovery for the datapath.
module fft_r22sdf_ctrl #(
    parameter int N_LOG2   = 6,
    parameter int MULT_LAT = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [N_LOG2/2-1:0]        bf1_sel_o,
    output logic [N_LOG2/2-1:0]        bf2_sel_o,
    output logic [N_LOG2/2-1:0]        bf2_tsel_o,
    output logic [N_LOG2/2*N_LOG2-1:0] tw_idx_o,
    output logic                       in_zero_o,
    output logic                       dp_rst_o,
    output logic                       out_valid_o,
    output logic                       out_last_o,
    output logic [N_LOG2-1:0]          out_idx_o,
    output logic                       err_o
);

    localparam int STAGES = N_LOG2 / 2;
    localparam int N      = 1 << N_LOG2;
    localparam int LAT    = (N - 1) + (STAGES - 1) * MULT_LAT;
    localparam int PEND_N = (LAT + N - 1) / N + 1;
    localparam int CW     = $clog2(LAT + 1);
    localparam logic [N_LOG2-1:0] G_ONE = N_LOG2'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    state_e                     state_q, state_d;
    logic [N_LOG2-1:0]          g_q, g_d;
    logic [CW-1:0]              drain_cnt_q, drain_cnt_d;
    logic [PEND_N-1:0]          pend_vld_q, pend_vld_d;
    logic [CW-1:0]              pend_cnt_q [PEND_N];
    logic [CW-1:0]              pend_cnt_d [PEND_N];
    logic                       out_valid_q, out_valid_d;
    logic [N_LOG2-1:0]          out_cnt_q, out_cnt_d;
    logic [STAGES-1:0]          bf1_q, bf1_d, bf2_q, bf2_d, tsel_q, tsel_d;
    logic [STAGES*N_LOG2-1:0]   tw_q, tw_d;

    logic accept, gap, frame_start, fire, loaded;

    always_comb begin
        ready_o = 1'b1;
        if (state_q == S_DRAIN) ready_o = (g_q == '0);
    end

    assign accept      = valid_i && ready_o;
    assign gap         = (state_q == S_RUN) && !valid_i && (g_q != '0);
    assign frame_start = accept && ((state_q != S_RUN) || (g_q == '0));

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    state_d = S_RUN;
                    g_d     = g_q + G_ONE;
                end
            end
            S_RUN: begin
                if (gap) begin
                    state_d = S_IDLE;
                    g_d     = '0;
                end else begin
                    g_d = g_q + G_ONE;
                    if (!valid_i) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = CW'(LAT);
                    end
                end
            end
            S_DRAIN: begin
                g_d         = g_q + G_ONE;
                drain_cnt_d = drain_cnt_q - CW'(1);
                if (accept) begin
                    state_d = S_RUN;
                end else if (drain_cnt_q == CW'(1)) begin
                    state_d     = S_IDLE;
                    g_d         = '0;
                    drain_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                g_d     = '0;
            end
        endcase
    end

    // Controls are registered from g_d so they line up with the sample carrying g_q.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int M = N_LOG2 - 2 * k;
        localparam logic [N_LOG2-1:0] OFF = N_LOG2'((k * MULT_LAT) % N);
        logic [M-1:0] c;
        assign c         = M'(g_d - OFF);
        assign bf1_d[k]  = c[M-1];
        assign bf2_d[k]  = c[M-2];
        assign tsel_d[k] = ~c[M-1];
        if (k < STAGES - 1) begin : g_tw
            logic [N_LOG2-1:0] r_w, low_w;
            assign r_w   = N_LOG2'({c[M-2], c[M-1]});
            assign low_w = N_LOG2'(c[M-3:0]);
            assign tw_d[k*N_LOG2 +: N_LOG2] = (r_w * low_w) << (2 * k);
        end else begin : g_tw_top
            assign tw_d[k*N_LOG2 +: N_LOG2] = '0;
        end
    end

    // Each frame start arms one latency tracker; it fires on the cycle before output begins.
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_cnt_d = pend_cnt_q;
        fire       = 1'b0;
        loaded     = 1'b0;
        for (int i = 0; i < PEND_N; i++) begin
            if (pend_vld_q[i]) begin
                if (pend_cnt_q[i] == CW'(1)) begin
                    fire          = 1'b1;
                    pend_vld_d[i] = 1'b0;
                end else begin
                    pend_cnt_d[i] = pend_cnt_q[i] - CW'(1);
                end
            end
        end
        if (frame_start) begin
            for (int i = 0; i < PEND_N; i++) begin
                if (!loaded && !pend_vld_d[i]) begin
                    pend_vld_d[i] = 1'b1;
                    pend_cnt_d[i] = CW'(LAT - 1);
                    loaded        = 1'b1;
                end
            end
        end
        if (gap) begin
            pend_vld_d = '0;
            fire       = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_cnt_d   = out_cnt_q;
        if (out_valid_q) begin
            if (&out_cnt_q) begin
                out_valid_d = fire;
                out_cnt_d   = '0;
            end else begin
                out_cnt_d = out_cnt_q + G_ONE;
            end
        end else if (fire) begin
            out_valid_d = 1'b1;
            out_cnt_d   = '0;
        end
        if (gap) begin
            out_valid_d = 1'b0;
            out_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            g_q         <= '0;
            drain_cnt_q <= '0;
            pend_vld_q  <= '0;
            for (int i = 0; i < PEND_N; i++) pend_cnt_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_cnt_q   <= '0;
            bf1_q       <= '0;
            bf2_q       <= '0;
            tsel_q      <= '0;
            tw_q        <= '0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            drain_cnt_q <= drain_cnt_d;
            pend_vld_q  <= pend_vld_d;
            for (int i = 0; i < PEND_N; i++) pend_cnt_q[i] <= pend_cnt_d[i];
            out_valid_q <= out_valid_d;
            out_cnt_q   <= out_cnt_d;
            bf1_q       <= bf1_d;
            bf2_q       <= bf2_d;
            tsel_q      <= tsel_d;
            tw_q        <= tw_d;
        end
    end

    always_comb begin
        out_idx_o = '0;
        for (int i = 0; i < N_LOG2; i++) out_idx_o[i] = out_cnt_q[N_LOG2-1-i];
    end

    // The first sample of a frame is accepted outside RUN, so it must not be zeroed.
    assign in_zero_o   = (state_q == S_RUN) ? 1'b0 : !accept;
    assign bf1_sel_o   = bf1_q;
    assign bf2_sel_o   = bf2_q;
    assign bf2_tsel_o  = tsel_q;
    assign tw_idx_o    = tw_q;
    assign err_o       = gap;
    assign dp_rst_o    = gap;
    assign out_valid_o = out_valid_q && !gap;
    assign out_last_o  = out_valid_o && (&out_cnt_q);

endmodule
